// File: rtl/local_packetizer.sv
// local_packetizer: network-interface transmitter for a router LOCAL input port.
// It takes a packet request (x/y destination and length) and a stream of
// payload words, then sends HEAD/BODY/TAIL/HEADTAIL flits. Each virtual
// channel has a credit counter that tracks free slots in the router's buffer.
module local_packetizer #(
    parameter int  MESH_SIZE_X      = 5,
    parameter int  MESH_SIZE_Y      = 7,
    parameter int  VC_NUM           = 2,
    parameter int  BUFFER_SIZE      = 8,
    parameter int  FLIT_DATA_SIZE   = 32,
    parameter int  MAX_PACKET_LEN   = 8,
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X),
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y),
    localparam int VC_W             = $clog2(VC_NUM),
    localparam int LEN_W            = $clog2(MAX_PACKET_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] req_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] req_y_dest_i,
    input  logic [LEN_W-1:0]            req_len_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]   data_i,
    input  logic                        credit_i,
    input  logic [VC_W-1:0]             credit_vc_i,
    output logic                        flit_valid_o,
    output logic [1:0]                  flit_label_o,
    output logic [VC_W-1:0]             flit_vc_o,
    output logic [FLIT_DATA_SIZE-1:0]   flit_data_o,
    output logic                        error_o
);

    localparam int                CRED_W    = $clog2(BUFFER_SIZE + 1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_PAYLOAD
    } state_t;

    typedef enum logic [1:0] {
        LBL_HEAD     = 2'b00,
        LBL_BODY     = 2'b01,
        LBL_TAIL     = 2'b10,
        LBL_HEADTAIL = 2'b11
    } label_t;

    state_t                      state;
    logic [CRED_W-1:0]           credit [VC_NUM];
    logic [DEST_ADDR_SIZE_X-1:0] x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            remaining;
    logic [VC_W-1:0]             held_vc;

    logic                        req_hs;
    logic                        req_bad;
    logic                        head_avail;
    logic [VC_W-1:0]             head_vc;
    logic [FLIT_DATA_SIZE-1:0]   head_data;
    logic                        data_hs;
    logic                        send;
    logic [VC_W-1:0]             send_vc;
    logic [VC_NUM-1:0]           credit_inc;
    logic [VC_NUM-1:0]           credit_dec;
    logic                        credit_overflow;

    assign req_ready_o  = (state == S_IDLE);
    assign req_hs       = req_valid_i & req_ready_o;
    assign data_ready_o = (state == S_PAYLOAD) && (credit[held_vc] != '0);
    assign data_hs      = data_valid_i & data_ready_o;

    // Request validation, head VC choice, head word and credit bookkeeping.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        req_bad         = 1'b0;
        head_avail      = 1'b0;
        head_vc         = '0;
        head_data       = '0;
        send            = 1'b0;
        send_vc         = held_vc;
        credit_inc      = '0;
        credit_dec      = '0;
        credit_overflow = 1'b0;

        if (req_len_i == '0
            || int'(req_len_i) > MAX_PACKET_LEN
            || int'(req_x_dest_i) >= MESH_SIZE_X
            || int'(req_y_dest_i) >= MESH_SIZE_Y)
            req_bad = 1'b1;

        // Walking downward lets the lowest VC with credit win.
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (credit[i] != '0) begin
                head_avail = 1'b1;
                head_vc    = VC_W'(i);
            end
        end

        head_data[DEST_ADDR_SIZE_X-1:0]                                = x_q;
        head_data[DEST_ADDR_SIZE_X+DEST_ADDR_SIZE_Y-1:DEST_ADDR_SIZE_X] = y_q;

        if (state == S_HEAD && head_avail) begin
            send    = 1'b1;
            send_vc = head_vc;
        end else if (data_hs) begin
            send    = 1'b1;
            send_vc = held_vc;
        end

        for (int i = 0; i < VC_NUM; i++) begin
            credit_inc[i] = credit_i && (credit_vc_i == VC_W'(i));
            credit_dec[i] = send && (send_vc == VC_W'(i));
            if (credit_inc[i] && !credit_dec[i] && credit[i] == CRED_FULL)
                credit_overflow = 1'b1;
        end
    end

    // Per-VC credit counters. A send and a returned credit in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the credit array is reset explicitly because its reset value is the downstream buffer depth, not zero.
            for (int i = 0; i < VC_NUM; i++)
                credit[i] <= CRED_FULL;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                if (credit_dec[i] && !credit_inc[i])
                    credit[i] <= credit[i] - 1'b1;
                else if (credit_inc[i] && !credit_dec[i] && credit[i] != CRED_FULL)
                    credit[i] <= credit[i] + 1'b1;
            end
        end
    end

    // Packet FSM that also drives the registered flit and error outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            len_q        <= '0;
            remaining    <= '0;
            held_vc      <= '0;
            flit_valid_o <= 1'b0;
            flit_label_o <= '0;
            flit_vc_o    <= '0;
            flit_data_o  <= '0;
            error_o      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates from values taken before the edge.
            flit_valid_o <= 1'b0;
            error_o      <= (req_hs && req_bad) || credit_overflow;

            case (state)
                S_IDLE: begin
                    if (req_hs && !req_bad) begin
                        x_q   <= req_x_dest_i;
                        y_q   <= req_y_dest_i;
                        len_q <= req_len_i;
                        state <= S_HEAD;
                    end
                end

                S_HEAD: begin
                    if (head_avail) begin
                        flit_valid_o <= 1'b1;
                        flit_vc_o    <= head_vc;
                        flit_data_o  <= head_data;
                        held_vc      <= head_vc;
                        remaining    <= len_q - 1'b1;
                        if (len_q == LEN_W'(1)) begin
                            flit_label_o <= LBL_HEADTAIL;
                            state        <= S_IDLE;
                        end else begin
                            flit_label_o <= LBL_HEAD;
                            state        <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (data_hs) begin
                        flit_valid_o <= 1'b1;
                        flit_vc_o    <= held_vc;
                        flit_data_o  <= data_i;
                        remaining    <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            flit_label_o <= LBL_TAIL;
                            state        <= S_IDLE;
                        end else begin
                            flit_label_o <= LBL_BODY;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
